// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_pkg
// Description : Shared types and constants for the SD data-line datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_pkg;

    localparam int unsigned SD_BLOCK_NIBBLES = 1024;
    localparam logic [15:0] SD_CRC16_POLY    = 16'h1021;

    localparam logic [2:0] TOK_OK   = 3'b010;
    localparam logic [2:0] TOK_CRC  = 3'b101;
    localparam logic [2:0] TOK_WERR = 3'b110;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_NWR       = 4'd2,
        ST_START     = 4'd3,
        ST_DATA      = 4'd4,
        ST_CRC       = 4'd5,
        ST_END       = 4'd6,
        ST_REL       = 4'd7,
        ST_STAT_WAIT = 4'd8,
        ST_STAT      = 4'd9,
        ST_BUSYW     = 4'd10,
        ST_DONE      = 4'd11
    } sd_wr_state_t;

endpackage
`default_nettype wire

// File: rtl/sd_crc16.sv
`default_nettype none
// ============================================================================
// Module      : sd_crc16
// Description : Bit-serial CRC16 for one SD DAT line, with clear, update
//               and MSB-first shift-out modes.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_crc16
    import sd_pkg::*;
#(
    parameter logic [15:0] POLY = SD_CRC16_POLY
) (
    input  logic        SD_clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        shift,
    input  logic        din,
    output logic [15:0] crc
);

    logic w_fb;
    assign w_fb = din ^ crc[15];

    always_ff @(posedge SD_clk) begin
        if (!rst_n || clr) begin
            crc <= 16'h0000;
        end else if (shift) begin
            crc <= {crc[14:0], 1'b0};
        end else if (en) begin
            crc <= {crc[14:0], 1'b0} ^ (w_fb ? POLY : 16'h0000);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sd_dat_write.sv
`default_nettype none
// ============================================================================
// Module      : sd_dat_write
// Description : SD 4-bit host block writer: frames one 512-byte block with
//               per-line CRC16, then collects the CRC status and busy phase.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_dat_write
    import sd_pkg::*;
#(
    parameter int unsigned CRC_TIMEOUT  = 64,
    parameter int unsigned BUSY_TIMEOUT = 1562500
) (
    input  logic       SD_clk,
    input  logic       rst_n,
    input  logic       write_req,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [3:0] data_out,
    output logic       data_oe,
    input  logic [3:0] data_in,
    output logic       busy,
    output logic       write_done,
    output logic       write_ok,
    output logic [2:0] wr_status
);

    sd_wr_state_t r_state;
    logic [9:0]   r_cnt;
    logic [20:0]  r_tmo;
    logic [7:0]   r_byte;
    logic [2:0]   r_tok;

    logic [3:0]   w_nib;
    logic [3:0]   w_crc_msb;
    logic [3:0]   w_unused_crc;
    logic         w_unused_dat;
    logic         w_underrun;

    assign w_unused_dat = ^data_in[3:1];

    // Even nibble index carries the high half of the current byte.
    assign w_nib      = r_cnt[0] ? r_byte[3:0] : r_byte[7:4];
    assign din_ready  = (r_state == ST_FETCH) ||
                        ((r_state == ST_DATA) && r_cnt[0] &&
                         (r_cnt != 10'(SD_BLOCK_NIBBLES - 1)));
    assign w_underrun = (r_state == ST_DATA) && din_ready && !din_valid;
    assign busy       = (r_state != ST_IDLE);

    generate
        for (genvar i = 0; i < 4; i++) begin : g_crc
            logic [15:0] w_crc;
            sd_crc16 u_crc (
                .SD_clk (SD_clk),
                .rst_n  (rst_n),
                .clr    (r_state == ST_IDLE),
                .en     ((r_state == ST_DATA) && !w_underrun),
                .shift  (r_state == ST_CRC),
                .din    (w_nib[i]),
                .crc    (w_crc)
            );
            assign w_crc_msb[i]    = w_crc[15];
            assign w_unused_crc[i] = ^w_crc[14:0];
        end
    endgenerate

    always_ff @(posedge SD_clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 10'd0;
            r_tmo      <= 21'd0;
            r_byte     <= 8'h00;
            r_tok      <= 3'b000;
            data_oe    <= 1'b0;
            data_out   <= 4'hF;
            write_done <= 1'b0;
            write_ok   <= 1'b0;
            wr_status  <= 3'b000;
        end else begin
            write_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    data_oe  <= 1'b0;
                    data_out <= 4'hF;
                    if (write_req) begin
                        r_state   <= ST_FETCH;
                        r_tok     <= 3'b000;
                        write_ok  <= 1'b0;
                        wr_status <= 3'b000;
                    end
                end
                ST_FETCH: begin
                    if (din_valid) begin
                        r_byte  <= din;
                        r_cnt   <= 10'd0;
                        r_state <= ST_NWR;
                    end
                end
                ST_NWR: begin
                    data_oe  <= 1'b1;
                    data_out <= 4'hF;
                    r_cnt    <= r_cnt + 10'd1;
                    if (r_cnt == 10'd1) begin
                        r_cnt   <= 10'd0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    data_out <= 4'h0;
                    r_cnt    <= 10'd0;
                    r_state  <= ST_DATA;
                end
                ST_DATA: begin
                    if (w_underrun) begin
                        data_oe    <= 1'b0;
                        data_out   <= 4'hF;
                        write_done <= 1'b1;
                        write_ok   <= 1'b0;
                        wr_status  <= 3'b000;
                        r_state    <= ST_DONE;
                    end else begin
                        data_out <= w_nib;
                        // The byte register is free once its low nibble goes out.
                        if (din_ready) begin
                            r_byte <= din;
                        end
                        r_cnt <= r_cnt + 10'd1;
                        if (r_cnt == 10'(SD_BLOCK_NIBBLES - 1)) begin
                            r_cnt   <= 10'd0;
                            r_state <= ST_CRC;
                        end
                    end
                end
                ST_CRC: begin
                    data_out <= w_crc_msb;
                    r_cnt    <= r_cnt + 10'd1;
                    if (r_cnt == 10'd15) begin
                        r_cnt   <= 10'd0;
                        r_state <= ST_END;
                    end
                end
                ST_END: begin
                    data_out <= 4'hF;
                    r_cnt    <= 10'd0;
                    r_tmo    <= 21'd0;
                    r_state  <= ST_REL;
                end
                ST_REL: begin
                    data_oe <= 1'b0;
                    r_tmo   <= r_tmo + 21'd1;
                    r_cnt   <= r_cnt + 10'd1;
                    if (r_cnt == 10'd1) begin
                        r_state <= ST_STAT_WAIT;
                    end
                end
                ST_STAT_WAIT: begin
                    r_tmo <= r_tmo + 21'd1;
                    if (!data_in[0]) begin
                        r_cnt   <= 10'd0;
                        r_state <= ST_STAT;
                    end else if (r_tmo >= 21'(CRC_TIMEOUT)) begin
                        write_done <= 1'b1;
                        write_ok   <= 1'b0;
                        wr_status  <= 3'b111;
                        r_state    <= ST_DONE;
                    end
                end
                ST_STAT: begin
                    r_cnt <= r_cnt + 10'd1;
                    if (r_cnt < 10'd3) begin
                        r_tok <= {r_tok[1:0], data_in[0]};
                    end else begin
                        // End bit cycle: the token is complete.
                        wr_status <= r_tok;
                        if (r_tok == TOK_OK) begin
                            r_tmo   <= 21'd0;
                            r_state <= ST_BUSYW;
                        end else begin
                            write_done <= 1'b1;
                            write_ok   <= 1'b0;
                            r_state    <= ST_DONE;
                        end
                    end
                end
                ST_BUSYW: begin
                    r_tmo <= r_tmo + 21'd1;
                    if (data_in[0]) begin
                        write_done <= 1'b1;
                        write_ok   <= 1'b1;
                        r_state    <= ST_DONE;
                    end else if (r_tmo == 21'(BUSY_TIMEOUT - 1)) begin
                        write_done <= 1'b1;
                        write_ok   <= 1'b0;
                        wr_status  <= 3'b000;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
